// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache line refill controller.
package cache_pkg;

  localparam int WORDS_PER_LINE_DEF = 4;
  localparam int NUM_WAYS_DEF       = 4;
  localparam int TAG_W_DEF          = 19;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EVICT  = 3'd2,
    FILL   = 3'd3,
    UPDATE = 3'd4
  } state_t;

endpackage

// File: rtl/cache_victim_sel.sv
// Replacement choice: first empty way, otherwise the way after the MRU one.
module cache_victim_sel #(
  parameter  int NUM_WAYS = 4,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] way_vld,
  input  logic [WAY_W-1:0]    mru_way,
  output logic [WAY_W-1:0]    victim_way
);

  // Scanning downward lets the lowest-index empty way win; the add wraps mod NUM_WAYS.
  always_comb begin
    victim_way = mru_way + 1'b1;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!way_vld[i]) victim_way = WAY_W'(i);
    end
  end

endmodule

// File: rtl/cache_line_refill_ctrl.sv
// Miss handler: picks a victim, writes it back when dirty, refills the line
// from L2 (merging store data on write misses) and strobes the array update.
module cache_line_refill_ctrl
  import cache_pkg::*;
#(
  parameter  int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter  int NUM_WAYS       = NUM_WAYS_DEF,
  parameter  int TAG_W          = TAG_W_DEF,
  localparam int OFF_W          = $clog2(WORDS_PER_LINE),
  localparam int WAY_W          = $clog2(NUM_WAYS),
  localparam int IDX_W          = 30 - TAG_W - OFF_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_miss,
  input  logic                        wr_miss,
  input  logic [31:0]                 miss_addr,
  input  logic [31:0]                 wr_miss_data,
  input  logic [NUM_WAYS-1:0]         way_vld,
  input  logic [WAY_W-1:0]            mru_way,
  input  logic                        victim_dirty,
  input  logic [TAG_W-1:0]            victim_tag,
  input  logic [32*WORDS_PER_LINE-1:0] victim_line,
  output logic [31:0]                 l2_mem_access_addr,
  output logic                        rd_en,
  input  logic                        l2_bus_arbiter_rd_granted,
  input  logic [31:0]                 l2_mem_rd_data,
  output logic                        l2_mem_wr_en,
  output logic [31:0]                 l2_mem_wr_data,
  input  logic                        l2_bus_arbiter_wr_granted,
  output logic                        upd_entry,
  output logic [32*WORDS_PER_LINE-1:0] upd_data_entry,
  output logic [TAG_W:0]              upd_entry_tag_vld,
  output logic [WAY_W-1:0]            blk_chosen_for_upd,
  output logic                        busy,
  output state_t                      fsm_state
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_t                        state;
  logic [OFF_W-1:0]              beat;
  logic [OFF_W-1:0]              beat_nxt;
  logic [29:0]                   word_q;
  logic [31:0]                   wdata_q;
  logic                          is_wr_q;
  logic                          victim_vld_q;
  logic [TAG_W-1:0]              victim_tag_q;
  logic [32*WORDS_PER_LINE-1:0]  victim_line_q;
  logic [WAY_W-1:0]              victim_way;
  logic [31:0]                   merge_word;
  logic                          unused_addr_lsb;

  cache_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_victim_sel (
    .way_vld    (way_vld),
    .mru_way    (mru_way),
    .victim_way (victim_way)
  );

  function automatic logic [31:0] word_addr(input logic [29-OFF_W:0] line, input logic [OFF_W-1:0] b);
    return {2'b00, line, b};
  endfunction

  assign beat_nxt        = beat + 1'b1;
  assign busy            = (state != IDLE);
  assign fsm_state       = state;
  assign merge_word      = (is_wr_q && beat == word_q[OFF_W-1:0]) ? wdata_q : l2_mem_rd_data;
  assign unused_addr_lsb = ^miss_addr[1:0];

  // Request/grant: rd_en or l2_mem_wr_en holds its address and data steady
  // until a cycle with the matching grant high; that cycle completes the beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      beat               <= '0;
      word_q             <= '0;
      wdata_q            <= '0;
      is_wr_q            <= 1'b0;
      victim_vld_q       <= 1'b0;
      victim_tag_q       <= '0;
      victim_line_q      <= '0;
      blk_chosen_for_upd <= '0;
      rd_en              <= 1'b0;
      l2_mem_wr_en       <= 1'b0;
      l2_mem_access_addr <= '0;
      l2_mem_wr_data     <= '0;
      upd_entry          <= 1'b0;
      upd_data_entry     <= '0;
      upd_entry_tag_vld  <= '0;
    end else begin
      upd_entry <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_miss || wr_miss) begin
            word_q             <= miss_addr[31:2];
            wdata_q            <= wr_miss_data;
            is_wr_q            <= wr_miss;
            blk_chosen_for_upd <= victim_way;
            victim_vld_q       <= &way_vld;
            state              <= SELECT;
          end
        end
        SELECT: begin
          victim_tag_q  <= victim_tag;
          victim_line_q <= victim_line;
          beat          <= '0;
          if (victim_vld_q && victim_dirty) begin
            l2_mem_wr_en       <= 1'b1;
            l2_mem_access_addr <= word_addr({victim_tag, word_q[IDX_W+OFF_W-1:OFF_W]}, '0);
            l2_mem_wr_data     <= victim_line[31:0];
            state              <= EVICT;
          end else begin
            rd_en              <= 1'b1;
            l2_mem_access_addr <= word_addr(word_q[29:OFF_W], '0);
            state              <= FILL;
          end
        end
        EVICT: begin
          if (l2_bus_arbiter_wr_granted) begin
            if (beat == LAST_BEAT) begin
              beat               <= '0;
              l2_mem_wr_en       <= 1'b0;
              rd_en              <= 1'b1;
              l2_mem_access_addr <= word_addr(word_q[29:OFF_W], '0);
              state              <= FILL;
            end else begin
              beat               <= beat_nxt;
              l2_mem_access_addr <= word_addr({victim_tag_q, word_q[IDX_W+OFF_W-1:OFF_W]}, beat_nxt);
              l2_mem_wr_data     <= victim_line_q[{beat_nxt, 5'd0} +: 32];
            end
          end
        end
        FILL: begin
          if (l2_bus_arbiter_rd_granted) begin
            upd_data_entry[{beat, 5'd0} +: 32] <= merge_word;
            if (beat == LAST_BEAT) begin
              beat              <= '0;
              rd_en             <= 1'b0;
              upd_entry         <= 1'b1;
              upd_entry_tag_vld <= {1'b1, word_q[29:30-TAG_W]};
              state             <= UPDATE;
            end else begin
              beat               <= beat_nxt;
              l2_mem_access_addr <= word_addr(word_q[29:OFF_W], beat_nxt);
            end
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_refill_ctrl.sv
// Bench for cache_line_refill_ctrl: a 4-word/4-way and an 8-word/2-way instance,
// one active at a time, against an expected-beat and expected-update scoreboard.
module tb_cache_line_refill_ctrl;
  import cache_pkg::*;

  logic         clk, rst_n, sel;
  logic         rd_miss, wr_miss;
  logic [31:0]  miss_addr, wr_miss_data;
  logic [3:0]   way_vld;
  logic [1:0]   mru_way;
  logic         victim_dirty;
  logic [18:0]  victim_tag;
  logic [255:0] victim_line;
  logic         rd_gnt, wr_gnt;
  logic [31:0]  l2_rd_data;

  logic [31:0]  addr_a, addr_b, wdata_a, wdata_b;
  logic         rd_en_a, rd_en_b, wr_en_a, wr_en_b, upd_a, upd_b, busy_a, busy_b;
  logic [127:0] line_a;
  logic [255:0] line_b;
  logic [19:0]  tagv_a, tagv_b;
  logic [1:0]   blk_a;
  logic [0:0]   blk_b;
  state_t       state_a, state_b;

  logic [31:0]  addr_m, wdata_m;
  logic         rd_en_m, wr_en_m, upd_m, busy_m;
  logic [255:0] line_m;
  logic [19:0]  tagv_m;
  logic [1:0]   blk_m;
  logic [2:0]   state_m;

  logic [64:0]  exp_q[$];        // {is_write, addr, write data}
  int           exp_way_q[$];
  logic [19:0]  exp_tag_q[$];
  logic [255:0] exp_line_q[$];

  int tests_run = 0, tests_failed = 0;
  int cyc = 0, upd_seen = 0, upd_cyc = 0, rd_beats = 0, stall_left = 0;
  bit overlap_seen = 0;

  cache_line_refill_ctrl #(.WORDS_PER_LINE(4), .NUM_WAYS(4), .TAG_W(19)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_miss(rd_miss & ~sel), .wr_miss(wr_miss & ~sel),
    .miss_addr(miss_addr), .wr_miss_data(wr_miss_data), .way_vld(way_vld), .mru_way(mru_way),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line[127:0]),
    .l2_mem_access_addr(addr_a), .rd_en(rd_en_a), .l2_bus_arbiter_rd_granted(rd_gnt),
    .l2_mem_rd_data(l2_rd_data), .l2_mem_wr_en(wr_en_a), .l2_mem_wr_data(wdata_a),
    .l2_bus_arbiter_wr_granted(wr_gnt), .upd_entry(upd_a), .upd_data_entry(line_a),
    .upd_entry_tag_vld(tagv_a), .blk_chosen_for_upd(blk_a), .busy(busy_a), .fsm_state(state_a));

  cache_line_refill_ctrl #(.WORDS_PER_LINE(8), .NUM_WAYS(2), .TAG_W(19)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_miss(rd_miss & sel), .wr_miss(wr_miss & sel),
    .miss_addr(miss_addr), .wr_miss_data(wr_miss_data), .way_vld(way_vld[1:0]), .mru_way(mru_way[0]),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line),
    .l2_mem_access_addr(addr_b), .rd_en(rd_en_b), .l2_bus_arbiter_rd_granted(rd_gnt),
    .l2_mem_rd_data(l2_rd_data), .l2_mem_wr_en(wr_en_b), .l2_mem_wr_data(wdata_b),
    .l2_bus_arbiter_wr_granted(wr_gnt), .upd_entry(upd_b), .upd_data_entry(line_b),
    .upd_entry_tag_vld(tagv_b), .blk_chosen_for_upd(blk_b), .busy(busy_b), .fsm_state(state_b));

  assign addr_m  = sel ? addr_b  : addr_a;
  assign wdata_m = sel ? wdata_b : wdata_a;
  assign rd_en_m = sel ? rd_en_b : rd_en_a;
  assign wr_en_m = sel ? wr_en_b : wr_en_a;
  assign upd_m   = sel ? upd_b   : upd_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign line_m  = sel ? line_b  : {128'b0, line_a};
  assign tagv_m  = sel ? tagv_b  : tagv_a;
  assign blk_m   = sel ? {1'b0, blk_b} : blk_a;
  assign state_m = sel ? state_b : state_a;
  // L2 returns the word address as its data.
  assign l2_rd_data = addr_m;

  // Clock and reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // L2 arbiter: grants every cycle, except the optional stall on read beat 1.
  initial begin
    rd_gnt = 0;
    wr_gnt = 0;
    forever begin
      @(posedge clk); #1;
      rd_gnt = 1;
      wr_gnt = 1;
      if (stall_left > 0 && rd_en_m && (addr_m & (sel ? 32'd7 : 32'd3)) == 32'd1) begin
        rd_gnt = 0;
        stall_left--;
      end
    end
  end

  task automatic pop_beat(input bit kind, input logic [31:0] a, input logic [31:0] d);
    logic [64:0] e;
    if (exp_q.size() == 0) begin
      check("beat_unexpected", {kind, a}, 33'h0);
    end else begin
      e = exp_q.pop_front();
      check("beat_kind", kind, e[64]);
      check("beat_addr", a, e[63:32]);
      if (kind) check("beat_wdata", d, e[31:0]);
    end
  endtask

  // Monitor: beats complete on the posedge following a negedge with request and grant high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_en_m && wr_en_m) overlap_seen = 1;
        if (wr_en_m && wr_gnt) begin
          pop_beat(1'b1, addr_m, wdata_m);
        end else if (rd_en_m && rd_gnt) begin
          pop_beat(1'b0, addr_m, 32'h0);
          rd_beats++;
        end else if (rd_en_m && exp_q.size() > 0) begin
          check("stall_addr", addr_m, exp_q[0][63:32]);
        end
        if (upd_m) begin
          if (exp_way_q.size() == 0) begin
            check("upd_unexpected", upd_m, 1'b0);
          end else begin
            check("upd_way", blk_m, exp_way_q.pop_front());
            check("upd_tag_vld", tagv_m, exp_tag_q.pop_front());
            check("upd_line", line_m, exp_line_q.pop_front());
          end
          upd_seen++;
          upd_cyc = cyc;
        end
      end
    end
  end

  task automatic check_idle(input string pfx);
    check({pfx, "_rd_en"}, rd_en_m, 1'b0);
    check({pfx, "_wr_en"}, wr_en_m, 1'b0);
    check({pfx, "_busy"}, busy_m, 1'b0);
    check({pfx, "_upd"}, upd_m, 1'b0);
    check({pfx, "_addr"}, addr_m, 32'h0);
    check({pfx, "_wdata"}, wdata_m, 32'h0);
    check({pfx, "_line"}, line_m, 256'h0);
    check({pfx, "_way"}, blk_m, 2'd0);
    check({pfx, "_tag_vld"}, tagv_m, 20'h0);
    check({pfx, "_state"}, state_m, IDLE);
  endtask

  // Builds the expected beats/update for one miss, then drives it for one cycle.
  task automatic start_miss(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] vld, input int mru, input bit dirty, input logic [18:0] vtag,
                            output int way, output logic [255:0] line, output bit evict,
                            output int start, output int seen0);
    int nw, wpl;
    logic [3:0] nw_mask;
    logic [31:0] wa, mask, fa, ea;
    logic [255:0] vl;
    nw = sel ? 2 : 4;
    wpl = sel ? 8 : 4;
    nw_mask = sel ? 4'h3 : 4'hF;
    mask = wpl - 1;
    way = (mru + 1) % nw;
    for (int i = nw - 1; i >= 0; i--) if (!vld[i]) way = i;
    evict = dirty && ((vld & nw_mask) == nw_mask);
    for (int b = 0; b < 8; b++) vl[b*32 +: 32] = $urandom;
    wa = addr >> 2;
    if (evict) begin
      for (int b = 0; b < wpl; b++) begin
        ea = {2'b00, vtag, 11'b0} | ((wa & 32'h7FF) & ~mask) | b;
        exp_q.push_back({1'b1, ea, vl[b*32 +: 32]});
      end
    end
    line = '0;
    for (int b = 0; b < wpl; b++) begin
      fa = (wa & ~mask) | b;
      exp_q.push_back({1'b0, fa, 32'h0});
      line[b*32 +: 32] = (wr && b == (wa & mask)) ? wdata : fa;
    end
    exp_way_q.push_back(way);
    exp_tag_q.push_back({1'b1, addr[31:13]});
    exp_line_q.push_back(line);
    @(posedge clk); #1;
    way_vld = vld;
    mru_way = mru[1:0];
    victim_dirty = dirty;
    victim_tag = vtag;
    victim_line = vl;
    miss_addr = addr;
    wr_miss_data = wdata;
    rd_miss = rd;
    wr_miss = wr;
    overlap_seen = 0;
    start = cyc;
    seen0 = upd_seen;
    @(posedge clk); #1;
    rd_miss = 0;
    wr_miss = 0;
    check("busy_select", busy_m, 1'b1);
  endtask

  task automatic finish_miss(input int way, input logic [255:0] line, input int start, input int seen0,
                             input bit check_lat);
    for (int i = 0; i < 300 && upd_seen == seen0; i++) @(posedge clk);
    if (upd_seen == seen0) begin
      check("timeout_upd", 1'b0, 1'b1);
      exp_q.delete();
      exp_way_q.delete();
      exp_tag_q.delete();
      exp_line_q.delete();
    end else if (check_lat) begin
      check("latency", upd_cyc - start, (sel ? 8 : 4) + 2);
    end
    repeat (3) @(posedge clk);
    #1;
    check("exp_left", exp_q.size(), 0);
    check("rd_wr_exclusive", overlap_seen, 1'b0);
    check("busy_idle", busy_m, 1'b0);
    check("hold_way", blk_m, way);
    check("hold_line", line_m, line);
    check("stall_used", stall_left, 0);
  endtask

  task automatic run_miss(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] vld, input int mru, input bit dirty, input logic [18:0] vtag);
    int way, start, seen0;
    logic [255:0] line;
    bit evict;
    start_miss(rd, wr, addr, wdata, vld, mru, dirty, vtag, way, line, evict, start, seen0);
    finish_miss(way, line, start, seen0, !evict);
  endtask

  task automatic random_misses(input int n);
    int kind;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 2);
      run_miss(kind != 1, kind != 0, $urandom, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, sel ? 1 : 3), 1'($urandom_range(0, 1)), 19'($urandom));
    end
  endtask

  initial begin
    int way, start, seen0, rb0;
    logic [255:0] line;
    bit evict;
    rst_n = 0;
    sel = 0;
    rd_miss = 0;
    wr_miss = 0;
    miss_addr = 0;
    wr_miss_data = 0;
    way_vld = 0;
    mru_way = 0;
    victim_dirty = 0;
    victim_tag = 0;
    victim_line = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_a");
    rst_n = 1;

    // 4 words x 4 ways
    run_miss(1, 0, 32'h0000_1230, 32'h0, 4'b1011, 0, 1'b0, 19'h0);
    run_miss(1, 0, 32'h0ABC_D5E0, 32'h0, 4'b1111, 3, 1'b1, 19'h7FFFF);
    run_miss(0, 1, 32'h0000_2008, 32'hDEAD_BEEF, 4'b0111, 0, 1'b1, 19'h12345);
    run_miss(1, 1, 32'h8765_432C, 32'h1357_9BDF, 4'b1111, 1, 1'b0, 19'h00F0F);

    // Read grant stalled on beat 1, plus a miss pulse while busy that must be ignored
    stall_left = 5;
    start_miss(1, 0, 32'h0003_3340, 32'h0, 4'b1110, 2, 1'b0, 19'h0, way, line, evict, start, seen0);
    @(posedge clk); #1;
    rd_miss = 1;
    miss_addr = 32'hFFFF_FFF0;
    @(posedge clk); #1;
    rd_miss = 0;
    finish_miss(way, line, start, seen0, 1'b0);

    // Reset in the middle of a refill
    start_miss(1, 0, 32'h0004_5670, 32'h0, 4'b0001, 0, 1'b0, 19'h0, way, line, evict, start, seen0);
    rb0 = rd_beats;
    for (int i = 0; i < 100 && rd_beats - rb0 < 3; i++) begin
      @(posedge clk); #1;
    end
    check("rst_fill_reached", (rd_beats - rb0) >= 3, 1'b1);
    rst_n = 0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_way_q.delete();
    exp_tag_q.delete();
    exp_line_q.delete();
    check_idle("rst_fill");
    rst_n = 1;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_upd", upd_seen - seen0, 0);
    run_miss(1, 0, 32'h0000_1230, 32'h0, 4'b1011, 0, 1'b0, 19'h0);
    random_misses(6);

    // 8 words x 2 ways
    sel = 1;
    rst_n = 0;
    @(posedge clk); #1;
    check_idle("reset_b");
    rst_n = 1;
    run_miss(1, 0, 32'h0000_1230, 32'h0, 4'b0001, 0, 1'b0, 19'h0);
    run_miss(1, 0, 32'h0ABC_D5E0, 32'h0, 4'b0011, 1, 1'b1, 19'h7FFFF);
    run_miss(0, 1, 32'h0000_2008, 32'hDEAD_BEEF, 4'b0010, 0, 1'b1, 19'h12345);
    random_misses(6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_line_refill_ctrl.md
CACHE_LINE_REFILL_CTRL -- requirements
Module: cache_line_refill_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, 2..16.
- NUM_WAYS, 4, set-associative ways; power of two, 2..8.
- TAG_W, 19, tag width.
- Derived: OFF_W = log2(WORDS_PER_LINE); WAY_W = log2(NUM_WAYS); IDX_W = 30-TAG_W-OFF_W.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rd_miss  in  1  read miss request.
- wr_miss  in  1  write miss request.
- miss_addr  in  32  byte address of the missing access.
- wr_miss_data  in  32  store data for a write miss.
- way_vld  in  NUM_WAYS  valid bits of the addressed set.
- mru_way  in  WAY_W  most recently used way of the set.
- victim_dirty  in  1  dirty bit of the way on blk_chosen_for_upd.
- victim_tag  in  TAG_W  tag of that way.
- victim_line  in  32*WORDS_PER_LINE  data of that way; word 0 in the LSBs.
- l2_mem_access_addr  out  32  L2 word address.
- rd_en  out  1  L2 read request.
- l2_bus_arbiter_rd_granted  in  1  read beat completes this cycle.
- l2_mem_rd_data  in  32  read data, valid in the grant cycle.
- l2_mem_wr_en  out  1  L2 write request.
- l2_mem_wr_data  out  32  write data.
- l2_bus_arbiter_wr_granted  in  1  write beat completes this cycle.
- upd_entry  out  1  one-cycle cache array write strobe.
- upd_data_entry  out  32*WORDS_PER_LINE  refilled line.
- upd_entry_tag_vld  out  TAG_W+1  {valid=1, tag}.
- blk_chosen_for_upd  out  WAY_W  victim way.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states: IDLE, SELECT, EVICT, FILL, UPDATE.
REQ-004 IDLE -> SELECT when rd_miss|wr_miss; in that cycle, register miss_addr, wr_miss_data, the request type and the victim way.
REQ-005 Victim way: lowest-index way with way_vld=0; if all ways are valid, (mru_way+1) mod NUM_WAYS.
REQ-006 In SELECT, sample victim_dirty, victim_tag and victim_line. If the victim is valid and dirty, go to EVICT; otherwise go to FILL.
REQ-007 EVICT: assert l2_mem_wr_en, with beat counter b running 0..WORDS_PER_LINE-1.
- Address: zero-extended {victim_tag, idx, b}; idx = miss_addr[31-TAG_W:OFF_W+2].
- Data: word b of the latched line.
- b advances only on a grant. Go to FILL after the grant of the last beat.
REQ-008 FILL: assert rd_en, with beat counter b running 0..WORDS_PER_LINE-1.
- Address: zero-extended {miss_addr[31:OFF_W+2], b}.
- On each grant, capture l2_mem_rd_data into word b. Go to UPDATE after the last grant.
REQ-009 Write merge: on a write miss, word miss_addr[OFF_W+1:2] is captured from wr_miss_data instead of L2 data. The L2 read of that beat is still performed.
REQ-010 UPDATE lasts exactly one cycle.
- upd_entry=1; upd_entry_tag_vld={1'b1, miss_addr[31:32-TAG_W]}.
- upd_data_entry and blk_chosen_for_upd are stable from UPDATE until the next SELECT.
- Next state: IDLE.
REQ-011 rd_en and l2_mem_wr_en are never high together. A request stays high with a stable address and data until granted.
REQ-012 A grant received while the matching request is low is ignored.
REQ-013 Miss inputs are ignored while busy. If rd_miss and wr_miss are both high, the request is a write miss.
REQ-014 Latency with no eviction and grants every cycle: UPDATE is reached WORDS_PER_LINE+2 cycles after the IDLE miss cycle.
REQ-015 The beat counter wraps to 0 on leaving EVICT and on leaving FILL.

Reset
REQ-016 While rst_n=0 at a clock edge, the following clear to 0: state (IDLE), beat counter, line buffer, all latched fields and all outputs.
REQ-017 Reset mid-EVICT or mid-FILL abandons the transaction. No upd_entry is issued for it.

Structure
REQ-018 Package cache_pkg holds the FSM state enum and the default values of WORDS_PER_LINE, NUM_WAYS and TAG_W.
REQ-019 Victim selection (REQ-005) lives in sub-module cache_victim_sel, which is combinational and parametrised by NUM_WAYS.

Verification
REQ-020 Clean read miss, defaults:
- Stimulus: miss_addr=0x0000_1230, way_vld=4'b1011, grants every cycle, L2 returns word addresses.
- Response: victim way 2; rd_en addresses 0x48C..0x48F; one upd_entry; tag=0x00000; line = those four words.
REQ-021 Dirty eviction:
- Stimulus: all ways valid, mru_way=3, victim_dirty=1, victim_tag=0x7FFFF.
- Response: way 0 chosen; four writes precede the four reads; no cycle has both rd_en and l2_mem_wr_en high.
REQ-022 Write miss at offset 0x8 with wr_miss_data=0xDEADBEEF:
- Response: word 2 of the line = 0xDEADBEEF; the other words come from L2.
REQ-023 Stalled grants:
- Stimulus: rd grant held low for 5 cycles on beat 1.
- Response: address and rd_en stay constant through the stall; no beat is skipped or duplicated.
REQ-024 Reset mid-FILL:
- Stimulus: rst_n low after beat 2 of FILL.
- Response: next cycle IDLE, all outputs 0, no upd_entry; a new miss then completes normally.
REQ-025 Parameter sweep: WORDS_PER_LINE=8, NUM_WAYS=2 passes REQ-020 through REQ-022 with scaled addresses.
